// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Multi-channel programmable clock divider. Each channel counts enabled clk
// cycles up to its divisor D and toggles its divided clock on the terminal
// count, giving a half-period of D+1 cycles and a full period of 2*(D+1).
// A divisor of zero halts the channel. Divisors are written one channel at a
// time through a simple strobe interface that acknowledges every write with a
// single-cycle ack (valid channel) or err (channel index out of range).
//
// Optional build macro:
//   CLK_DIV_GLITCHFREE_EN - writes land in a per-channel shadow register and
//                           are transferred to the active divisor only at the
//                           next terminal count or while the channel is halted.
//                           Without it, a write takes effect immediately and
//                           restarts the channel's count from zero.
//
// Parameters:
//   CHANNELS  - number of independent channels (1..16)
//   WIDTH     - counter / divisor width
//   DIV_RESET - divisor loaded into every channel at reset
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous, active-high reset
//   en       - per-channel run enable
//   wr_en    - divisor write strobe
//   wr_ch    - target channel index
//   wr_data  - new divisor value
//   wr_ack   - one-cycle pulse, write accepted
//   wr_err   - one-cycle pulse, write rejected (wr_ch >= CHANNELS)
//   s_clk    - registered divided clock per channel
//   tick     - registered one-cycle pulse at each s_clk toggle
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 19,
  parameter int DIV_RESET = 499999,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                wr_ack,
  output logic                wr_err,
  output logic [CHANNELS-1:0] s_clk,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RESET);
  // One bit wider than wr_ch so that CHANNELS itself is representable.
  localparam logic [CW:0]      CH_LIMIT = (CW + 1)'(CHANNELS);

  logic wr_hit;
  logic wr_ack_reg;
  logic wr_err_reg;

  assign wr_hit = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

  // Write handshake: exactly one of ack/err for each strobe, one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack_reg <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      wr_ack_reg <= wr_hit;
      wr_err_reg <= wr_en && !wr_hit;
    end
  end

  assign wr_ack = wr_ack_reg;
  assign wr_err = wr_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam logic [CW-1:0] CH_IDX = CW'(gi);

      logic             wr_sel;
      logic             halted;
      logic             term;
      logic [WIDTH-1:0] div_reg,   div_next;
      logic [WIDTH-1:0] cnt_reg,   cnt_next;
      logic             s_clk_reg, s_clk_next;
      logic             tick_reg,  tick_next;

      assign wr_sel = wr_hit && (wr_ch == CH_IDX);
      assign halted = (div_reg == '0);
      assign term   = en[gi] && !halted && (cnt_reg == div_reg);

`ifdef CLK_DIV_GLITCHFREE_EN
      logic [WIDTH-1:0] shadow_reg,     shadow_next;
      logic             shadow_vld_reg, shadow_vld_next;
      logic             load_pending;
      logic [WIDTH-1:0] load_value;

      // A write arriving in the same cycle as a transfer point is treated as
      // the newest shadow content, so it takes effect at that transfer.
      assign load_pending = wr_sel || shadow_vld_reg;
      assign load_value   = wr_sel ? wr_data : shadow_reg;

      always_comb begin
        div_next        = div_reg;
        cnt_next        = cnt_reg;
        s_clk_next      = s_clk_reg;
        tick_next       = 1'b0;
        shadow_next     = shadow_reg;
        shadow_vld_next = shadow_vld_reg;
        if (wr_sel) begin
          shadow_next     = wr_data;
          shadow_vld_next = 1'b1;
        end
        if (halted) begin
          cnt_next = '0;
          if (load_pending) begin
            div_next        = load_value;
            shadow_vld_next = 1'b0;
          end
        end else if (term) begin
          // The toggle completing now was timed with the old divisor.
          cnt_next   = '0;
          s_clk_next = ~s_clk_reg;
          tick_next  = 1'b1;
          if (load_pending) begin
            div_next        = load_value;
            shadow_vld_next = 1'b0;
          end
        end else if (en[gi]) begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shadow_reg     <= '0;
          shadow_vld_reg <= 1'b0;
        end else begin
          shadow_reg     <= shadow_next;
          shadow_vld_reg <= shadow_vld_next;
        end
      end
`else
      always_comb begin
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        s_clk_next = s_clk_reg;
        tick_next  = 1'b0;
        if (wr_sel) begin
          // Immediate reload restarts the half-period; a coinciding terminal
          // count is deliberately swallowed so s_clk does not toggle early.
          div_next = wr_data;
          cnt_next = '0;
        end else if (halted) begin
          cnt_next = '0;
        end else if (term) begin
          cnt_next   = '0;
          s_clk_next = ~s_clk_reg;
          tick_next  = 1'b1;
        end else if (en[gi]) begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          div_reg   <= DIV_INIT;
          cnt_reg   <= '0;
          s_clk_reg <= 1'b0;
          tick_reg  <= 1'b0;
        end else begin
          div_reg   <= div_next;
          cnt_reg   <= cnt_next;
          s_clk_reg <= s_clk_next;
          tick_reg  <= tick_next;
        end
      end

      assign s_clk[gi] = s_clk_reg;
      assign tick[gi]  = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Directed self-checking bench for clk_div_prog in its default build
// (immediate divisor writes). Uses CHANNELS=5 so that an out-of-range channel
// index (5, 7) is representable on the 3-bit wr_ch port, and DIV_RESET=3 so
// that the reset half-period is 4 cycles. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int CHANNELS  = 5;
  localparam int WIDTH     = 8;
  localparam int DIV_RESET = 3;
  localparam int CW        = 3;

  logic                clk;
  logic                reset;
  logic [CHANNELS-1:0] en;
  logic                wr_en;
  logic [CW-1:0]       wr_ch;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_ack;
  logic                wr_err;
  logic [CHANNELS-1:0] s_clk;
  logic [CHANNELS-1:0] tick;

  int check_count = 0;
  int error_count = 0;

  clk_div_prog #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .DIV_RESET(DIV_RESET)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_data(wr_data),
    .wr_ack (wr_ack),
    .wr_err (wr_err),
    .s_clk  (s_clk),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tick[ch] is seen; n is the number of edges taken.
  task automatic wait_tick(input int ch, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < lim);
    if (!tick[ch]) check_eq("tick_timeout", 32'(n), 32'(lim + 1));
  endtask

  // Leaves reset asserted with quiet inputs; caller releases it.
  task automatic do_reset();
    reset   = 1'b1;
    en      = '0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    step();
    step();
  endtask

  task automatic write_div(input int ch, input int val);
    wr_en   = 1'b1;
    wr_ch   = CW'(ch);
    wr_data = WIDTH'(val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen_tick;
    logic seen_low;
    int ch1_ticks;

    // ---- reset values and reset-release timing ----
    do_reset();
    check_eq("rst_s_clk", s_clk, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_ack", wr_ack, 0);
    check_eq("rst_err", wr_err, 0);
    en    = '1;
    reset = 1'b0;
    wait_tick(0, 20, n);
    check_eq("first_toggle", n, 4);
    check_eq("all_s_clk_hi", s_clk, 5'h1F);
    check_eq("all_tick", tick, 5'h1F);
    wait_tick(0, 20, n);
    check_eq("half_period_d3", n, 4);
    check_eq("all_s_clk_lo", s_clk, 0);

    // ---- write D=1 to channel 2, others keep D=3 ----
    write_div(2, 1);
    step();
    check_eq("wr2_ack", wr_ack, 1);
    check_eq("wr2_err", wr_err, 0);
    wr_en = 1'b0;
    wait_tick(2, 20, n);
    check_eq("ch2_half_a", n, 2);
    wait_tick(2, 20, n);
    check_eq("ch2_half_b", n, 2);
    wait_tick(0, 20, n);
    check_eq("ch0_phase", n, 3);
    check_eq("others_tick", tick, 5'b11011);
    wait_tick(0, 20, n);
    check_eq("ch0_half", n, 4);

    // ---- out-of-range writes, back to back ----
    do_reset();
    en    = '1;
    reset = 1'b0;
    write_div(5, 1);
    step();
    check_eq("bad5_err", wr_err, 1);
    check_eq("bad5_ack", wr_ack, 0);
    write_div(7, 1);
    step();
    check_eq("bad7_err", wr_err, 1);
    wr_en = 1'b0;
    step();
    check_eq("bad_err_clear", wr_err, 0);
    wait_tick(0, 20, n);
    check_eq("bad_ch0_phase", n, 1);
    check_eq("bad_all_tick", tick, 5'h1F);

    // ---- write in the reset-release cycle, then a second write next cycle ----
    do_reset();
    en    = '1;
    reset = 1'b0;
    write_div(3, 2);
    step();
    check_eq("rel_ack", wr_ack, 1);
    write_div(4, 1);
    step();
    check_eq("b2b_ack", wr_ack, 1);
    check_eq("b2b_err", wr_err, 0);
    wr_en = 1'b0;
    wait_tick(4, 20, n);
    check_eq("ch4_first", n, 2);
    check_eq("b2b_tick_e4", tick, 5'h1F);
    wait_tick(4, 20, n);
    check_eq("ch4_half", n, 2);
    check_eq("ch4_only_tick", tick, 5'b10000);
    wait_tick(3, 20, n);
    check_eq("ch3_half", n, 1);
    check_eq("ch3_only_tick", tick, 5'b01000);

    // ---- D=0 halts channel 0, D=2 resumes ----
    do_reset();
    en    = '1;
    reset = 1'b0;
    wait_tick(0, 20, n);
    write_div(0, 0);
    step();
    wr_en     = 1'b0;
    seen_tick = tick[0];
    seen_low  = !s_clk[0];
    ch1_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_tick = seen_tick | tick[0];
      seen_low  = seen_low | !s_clk[0];
      if (tick[1]) ch1_ticks++;
    end
    check_eq("halt_tick", seen_tick, 0);
    check_eq("halt_s_clk_fall", seen_low, 0);
    check_eq("halt_ch1_ticks", ch1_ticks, 2);
    write_div(0, 2);
    step();
    wr_en = 1'b0;
    wait_tick(0, 20, n);
    check_eq("resume_first", n, 3);
    check_eq("resume_s_clk", s_clk[0], 0);
    wait_tick(0, 20, n);
    check_eq("resume_half", n, 3);

    // ---- write coinciding with terminal count (old D=3, new D=7) ----
    do_reset();
    en    = '1;
    reset = 1'b0;
    step();
    step();
    step();
    write_div(3, 7);
    step();
    wr_en = 1'b0;
    check_eq("tc_wr_tick", tick, 5'b10111);
    check_eq("tc_wr_s_clk3", s_clk[3], 0);
    check_eq("tc_wr_ack", wr_ack, 1);
    wait_tick(3, 20, n);
    check_eq("tc_wr_next", n, 8);

    // ---- enable pause on channel 1 at cnt=2, then mid-period reset ----
    do_reset();
    en    = '1;
    reset = 1'b0;
    step();
    step();
    en        = 5'b11101;
    seen_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen_tick = seen_tick | tick[1];
    end
    check_eq("pause_tick", seen_tick, 0);
    check_eq("pause_s_clk1", s_clk[1], 0);
    check_eq("pause_s_clk0", s_clk[0], 1);
    en = '1;
    wait_tick(1, 20, n);
    check_eq("pause_resume", n, 2);
    check_eq("pause_s_clk1_hi", s_clk[1], 1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_s_clk", s_clk, 0);
    check_eq("async_rst_tick", tick, 0);
    step();
    reset = 1'b0;
    wait_tick(0, 20, n);
    check_eq("rst_mid_first", n, 4);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
